bf_mem_arbiter: RTL and testbench
=================================

Name: bf_mem_arbiter

Overview:
- Shares the single external 8-bit memory bus of the BF processor tile between two requesters: the instruction-fetch unit and the data-pointer/cell unit.
- The bus consists of the address pins, the bidirectional data pins, and the output-enable bank, which doubles as the write strobe.
- Sequences each access through fixed setup/access phases, round-robin arbitrates simultaneous requests, and returns read data with a one-cycle acknowledge.

Parameters:
- SETUP_CYCLES, 1: cycles the address (and write data) is driven before the access phase; legal range 1..15.
- ACCESS_CYCLES, 2: cycles of the access phase; read data is sampled at the end of its last cycle; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  instruction-fetch request, level, held until if_ack
- if_addr  in  8  fetch address, stable while if_req high
- if_ack  out  1  one-cycle pulse: fetch done, if_rdata valid this cycle
- if_rdata  out  8  fetched byte, held until next fetch completes
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1=write, 0=read, stable while d_req high
- d_addr  in  8  data address
- d_wdata  in  8  write byte
- d_ack  out  1  one-cycle pulse: data access done
- d_rdata  out  8  read byte, held until next data read completes
- mem_addr  out  8  external address pins
- mem_wdata  out  8  external data-out pins
- mem_rdata  in  8  external data-in pins
- mem_oe  out  8  data pin enables; 8'hFF = drive/write, 8'h00 = input/read
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). Reset forces:
  - state=IDLE, all outputs 0 (mem_oe=8'h00 immediately, without waiting for a clock edge);
  - last_grant=DATA, so fetch wins the first contention.
- FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any request is high, grant at the clock edge and latch addr, we, and wdata of the winner.
  - Fetch is always a read (we=0).
  - Go to SETUP with cnt=SETUP_CYCLES-1.
  - No request: stay in IDLE.
- Arbitration: if both requests are high in IDLE, grant the requester not equal to last_grant; last_grant updates on every grant; a single request is granted regardless of last_grant.
- SETUP: mem_addr=latched addr; on a write, mem_wdata=latched wdata and mem_oe=8'hFF. Decrement cnt; at cnt==0 go to ACCESS with cnt=ACCESS_CYCLES-1.
- ACCESS: same outputs as SETUP. At cnt==0:
  - on a read, register mem_rdata into the granted port's rdata;
  - go to DONE.
- DONE (1 cycle): the granted port's ack=1; mem_oe=8'h00 (turnaround); mem_addr holds its value; next state is IDLE unconditionally.
- Latency: request sampled high in IDLE at edge E0 -> ack high during cycle E0+SETUP_CYCLES+ACCESS_CYCLES+1. With defaults, ack arrives 4 cycles after the request is sampled; minimum spacing between back-to-back grants is 5 cycles.
- Output holding rules:
  - mem_addr and mem_wdata keep their last values outside transactions; they are never forced to 0 except by reset.
  - mem_oe is nonzero only in SETUP/ACCESS of a write.
  - Exactly one ack can be high in a cycle, and only in DONE.
- Boundary conditions:
  - Input address/data changes after the grant are ignored; the latched values are used.
  - A request dropped mid-transaction: the transaction still completes and ack still pulses.
  - A requester still holding req in the cycle after its ack is treated as a new request.
  - Reset mid-transaction: the access is aborted, no ack is issued, and rdata returns to 0.
  - The non-granted requester waits with no loss; its req stays pending until it is served.

Test Plan:
- Reset then single fetch: if_addr=8'h10, mem_rdata=8'hA5 -> mem_addr=8'h10 from cycle 1; if_ack pulses in cycle 4; if_rdata=8'hA5; mem_oe stays 8'h00 throughout.
- Data write: d_we=1, d_addr=8'h80, d_wdata=8'h3C -> mem_oe=8'hFF and mem_wdata=8'h3C during cycles 1-3; mem_oe=8'h00 in DONE (cycle 4); d_ack pulses in cycle 4; if_ack stays 0.
- Contention: if_req and d_req raised together after reset -> fetch served first (if_ack cycle 4), data served next (d_ack cycle 9); then both raised again -> fetch served first again, since last_grant=DATA.
- Starvation check: d_req held high continuously while if_req pulses once per transaction -> grants alternate F,D,F,D across 6 transactions.
- Mid-transaction changes: drop d_req and change d_addr to 8'hFF during ACCESS -> mem_addr stays at the original address; d_ack still pulses.
- Async reset asserted during ACCESS of a write -> mem_oe=8'h00 and busy=0 before the next clock edge; no ack is issued; after release, a fresh fetch completes with normal 4-cycle latency. Repeat with SETUP_CYCLES=3, ACCESS_CYCLES=1 -> ack arrives 5 cycles after the request is sampled.

Source files
------------

// File: rtl/bf_mem_arbiter_if.sv
// Memory-bus bundle of the BF processor tile: the two requester ports
// (instruction fetch and data-pointer/cell unit) plus the external memory pins.
interface bf_mem_arbiter_if;
  // instruction-fetch requester
  logic       if_req;
  logic [7:0] if_addr;
  logic       if_ack;
  logic [7:0] if_rdata;
  // data requester
  logic       d_req;
  logic       d_we;
  logic [7:0] d_addr;
  logic [7:0] d_wdata;
  logic       d_ack;
  logic [7:0] d_rdata;
  // external memory bus
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] mem_oe;
  logic       busy;

  // arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_oe, busy
  );

  // requester / memory-model side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_oe, busy
  );
endinterface

// File: rtl/bf_mem_arbiter.sv
// Round-robin arbiter sharing the tile's single 8-bit memory bus between the
// instruction-fetch unit and the data unit. Each access runs a fixed
// SETUP -> ACCESS -> DONE sequence; DONE is the bus turnaround cycle in which
// the winner's one-cycle acknowledge is raised.
module bf_mem_arbiter #(
  parameter int SETUP_CYCLES  = 1,
  parameter int ACCESS_CYCLES = 2
) (
  input logic             clk,
  input logic             rst_n,
  bf_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  logic       r_gnt_d;      // current transaction belongs to the data unit
  logic       r_last_d;     // most recent grant went to the data unit
  logic       r_we;         // current transaction is a write
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_if_rdata;
  logic [7:0] r_d_rdata;

  logic       w_grant;
  logic       w_pick_d;
  logic       w_sample;
  logic       w_drive;

  // A grant happens on any request in IDLE; on contention the side that was
  // not served last wins, a lone request wins regardless of history.
  assign w_grant  = (r_state == S_IDLE) && (bus.if_req || bus.d_req);
  assign w_pick_d = bus.d_req && (!bus.if_req || !r_last_d);
  assign w_sample = (r_state == S_ACCESS) && (r_cnt == 4'd0) && !r_we;
  assign w_drive  = r_we && ((r_state == S_SETUP) || (r_state == S_ACCESS));

  // State and phase counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and phase-counter decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = 4'(SETUP_CYCLES - 1);
        end
      end
      S_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = 4'(ACCESS_CYCLES - 1);
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ACCESS: begin
        if (r_cnt == 4'd0) w_state_nxt = S_DONE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the winner's request at grant; later input changes are ignored.
  // Write data is only updated by writes so the pins hold their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_d  <= 1'b0;
      r_last_d <= 1'b1;
      r_we     <= 1'b0;
      r_addr   <= 8'h00;
      r_wdata  <= 8'h00;
    end else if (w_grant) begin
      r_gnt_d  <= w_pick_d;
      r_last_d <= w_pick_d;
      r_we     <= w_pick_d && bus.d_we;
      r_addr   <= w_pick_d ? bus.d_addr : bus.if_addr;
      if (w_pick_d && bus.d_we) r_wdata <= bus.d_wdata;
    end
  end

  // Capture read data at the end of the last access cycle into the winner's port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rdata <= 8'h00;
      r_d_rdata  <= 8'h00;
    end else if (w_sample) begin
      if (r_gnt_d) r_d_rdata  <= bus.mem_rdata;
      else         r_if_rdata <= bus.mem_rdata;
    end
  end

  // Outputs decode straight from state so reset clears them without a clock
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_oe    = {8{w_drive}};
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.if_ack    = (r_state == S_DONE) && !r_gnt_d;
  assign bus.d_ack     = (r_state == S_DONE) && r_gnt_d;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_bf_mem_arbiter.sv
// Directed testbench for bf_mem_arbiter: default-timing instance plus a
// SETUP_CYCLES=3 / ACCESS_CYCLES=1 instance for the latency variant.
module tb_bf_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  bf_mem_arbiter_if bus();
  bf_mem_arbiter_if bus2();

  bf_mem_arbiter #(.SETUP_CYCLES(1), .ACCESS_CYCLES(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bf_mem_arbiter #(.SETUP_CYCLES(3), .ACCESS_CYCLES(1)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // step until the wanted ack appears; k = cycle index of the ack, 0 on timeout
  task automatic wait_ack(input bit want_d, output int k);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.if_ack && bus.d_ack) check_eq("ack_excl", 32'(bus.if_ack & bus.d_ack), 0);
      if (want_d ? bus.d_ack : bus.if_ack) begin
        k = i;
        break;
      end
      if (want_d ? bus.if_ack : bus.d_ack) check_eq("wrong_ack", {31'd0, want_d}, {31'd0, ~want_d});
    end
  endtask

  // step until either ack; who = 1 fetch, 2 data, 0 timeout
  task automatic wait_any(output int who, output int k);
    who = 0;
    k   = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.if_ack || bus.d_ack) begin
        who = bus.if_ack ? 1 : 2;
        k   = i;
        break;
      end
    end
  endtask

  int k;
  int who;
  int exp_who;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
    bus2.if_req = 0; bus2.if_addr = 0; bus2.d_req = 0; bus2.d_we = 0;
    bus2.d_addr = 0; bus2.d_wdata = 0; bus2.mem_rdata = 0;

    // ---- reset state
    repeat (3) step();
    check_eq("rst_busy",     32'(bus.busy), 0);
    check_eq("rst_oe",       32'(bus.mem_oe), 0);
    check_eq("rst_addr",     32'(bus.mem_addr), 0);
    check_eq("rst_wdata",    32'(bus.mem_wdata), 0);
    check_eq("rst_if_rdata", 32'(bus.if_rdata), 0);
    check_eq("rst_acks",     32'({bus.if_ack, bus.d_ack}), 0);
    rst_n = 1'b1;
    step();

    // ---- single fetch
    bus.if_addr = 8'h10; bus.mem_rdata = 8'hA5; bus.if_req = 1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_eq($sformatf("f_addr_c%0d", c), 32'(bus.mem_addr), 32'h10);
      check_eq($sformatf("f_oe_c%0d", c),   32'(bus.mem_oe), 0);
      check_eq($sformatf("f_ack_c%0d", c),  32'(bus.if_ack), (c == 4) ? 1 : 0);
      check_eq($sformatf("f_busy_c%0d", c), 32'(bus.busy), 1);
    end
    check_eq("f_rdata", 32'(bus.if_rdata), 32'hA5);
    bus.if_req = 0;
    step();
    check_eq("f_idle_busy", 32'(bus.busy), 0);
    check_eq("f_idle_ack",  32'(bus.if_ack), 0);

    // ---- data write
    bus.d_we = 1; bus.d_addr = 8'h80; bus.d_wdata = 8'h3C; bus.d_req = 1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_eq($sformatf("w_addr_c%0d", c), 32'(bus.mem_addr), 32'h80);
      check_eq($sformatf("w_oe_c%0d", c),   32'(bus.mem_oe), (c <= 3) ? 32'hFF : 0);
      check_eq($sformatf("w_dack_c%0d", c), 32'(bus.d_ack), (c == 4) ? 1 : 0);
      check_eq($sformatf("w_iack_c%0d", c), 32'(bus.if_ack), 0);
      if (c <= 3) check_eq($sformatf("w_wdata_c%0d", c), 32'(bus.mem_wdata), 32'h3C);
    end
    bus.d_req = 0; bus.d_we = 0;
    step();
    check_eq("w_hold_wdata", 32'(bus.mem_wdata), 32'h3C);
    check_eq("w_hold_addr",  32'(bus.mem_addr), 32'h80);
    check_eq("w_idle_oe",    32'(bus.mem_oe), 0);

    // ---- contention: fetch first (last grant was data), then data
    bus.if_addr = 8'h22; bus.d_addr = 8'h44; bus.mem_rdata = 8'h5A;
    bus.if_req = 1; bus.d_req = 1;
    wait_ack(1'b0, k);
    check_eq("c1_f_lat", 32'(k), 4);
    check_eq("c1_f_rdata", 32'(bus.if_rdata), 32'h5A);
    bus.if_req = 0; bus.mem_rdata = 8'h77;
    wait_ack(1'b1, k);
    check_eq("c1_d_lat", 32'(k), 5);
    check_eq("c1_d_addr", 32'(bus.mem_addr), 32'h44);
    check_eq("c1_d_rdata", 32'(bus.d_rdata), 32'h77);
    check_eq("c1_if_rdata_hold", 32'(bus.if_rdata), 32'h5A);
    bus.d_req = 0;
    step();
    bus.if_req = 1; bus.d_req = 1;
    wait_ack(1'b0, k);
    check_eq("c2_f_lat", 32'(k), 4);
    bus.if_req = 0;
    wait_ack(1'b1, k);
    check_eq("c2_d_lat", 32'(k), 5);
    bus.d_req = 0;
    step();

    // ---- starvation: data held, fetch re-raised each idle window
    bus.d_req = 1;
    for (int t = 0; t < 6; t++) begin
      bus.if_req = 1;
      wait_any(who, k);
      exp_who = (t % 2 == 0) ? 1 : 2;
      check_eq($sformatf("rr_who_%0d", t), 32'(who), 32'(exp_who));
      check_eq($sformatf("rr_lat_%0d", t), 32'(k), 4);
      if (who == 1) bus.if_req = 0;
      step();
    end
    bus.d_req = 0; bus.if_req = 0;
    repeat (6) step();
    check_eq("rr_idle", 32'(bus.busy), 0);

    // ---- mid-transaction request drop and address change
    bus.d_we = 0; bus.d_addr = 8'h5C; bus.mem_rdata = 8'h99; bus.d_req = 1;
    step();
    step();
    bus.d_req = 0; bus.d_addr = 8'hFF;
    check_eq("mid_addr_c2", 32'(bus.mem_addr), 32'h5C);
    step();
    check_eq("mid_addr_c3", 32'(bus.mem_addr), 32'h5C);
    step();
    check_eq("mid_dack", 32'(bus.d_ack), 1);
    check_eq("mid_addr_c4", 32'(bus.mem_addr), 32'h5C);
    check_eq("mid_rdata", 32'(bus.d_rdata), 32'h99);
    step();
    check_eq("mid_idle", 32'(bus.busy), 0);

    // ---- async reset during ACCESS of a write
    bus.d_we = 1; bus.d_addr = 8'h31; bus.d_wdata = 8'hC3; bus.d_req = 1;
    step();
    step();
    check_eq("ar_oe_before", 32'(bus.mem_oe), 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_oe",    32'(bus.mem_oe), 0);
    check_eq("ar_busy",  32'(bus.busy), 0);
    check_eq("ar_rdata", 32'(bus.d_rdata), 0);
    check_eq("ar_addr",  32'(bus.mem_addr), 0);
    bus.d_req = 0; bus.d_we = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      check_eq($sformatf("ar_noack_%0d", c), 32'({bus.if_ack, bus.d_ack}), 0);
    end
    #2 rst_n = 1'b1;
    step();
    bus.if_addr = 8'h07; bus.mem_rdata = 8'h4E; bus.if_req = 1;
    wait_ack(1'b0, k);
    check_eq("ar_f_lat", 32'(k), 4);
    check_eq("ar_f_rdata", 32'(bus.if_rdata), 32'h4E);
    bus.if_req = 0;
    step();

    // ---- SETUP_CYCLES=3, ACCESS_CYCLES=1 instance
    bus2.if_addr = 8'h66; bus2.mem_rdata = 8'h12; bus2.if_req = 1;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bus2.mem_oe != 8'h00) check_eq("v_oe", 32'(bus2.mem_oe), 0);
      if (bus2.if_ack) begin
        k = c;
        break;
      end
    end
    check_eq("v_lat", 32'(k), 5);
    check_eq("v_rdata", 32'(bus2.if_rdata), 32'h12);
    check_eq("v_addr", 32'(bus2.mem_addr), 32'h66);
    bus2.if_req = 0;
    step();
    check_eq("v_idle", 32'(bus2.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
